// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 set-2 byte streams into key events and tracks held arrow/space keys
module ps2_key_tracker #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BYTE_VALID,
    input  logic [7:0] BYTE_DATA,
    input  logic       BYTE_ERR,
    output logic       EVT_VALID,
    output logic [7:0] EVT_CODE,
    output logic       EVT_EXT,
    output logic       EVT_RELEASE,
    output logic       EVT_REPEAT,
    output logic [4:0] KEY_STATE,
    output logic       SEQ_ERR
);
    localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0] IDLE = 3'd0, EXT = 3'd1, BRK = 3'd2, EXT_BRK = 3'd3, SKIP = 3'd4;

    logic [2:0] state, nxt;
    logic [2:0] skip;
    logic [TW-1:0] tcnt;
    logic ev, ev_ext, ev_rel, err;
    logic is_e0, is_f0, is_e1;
    logic [4:0] mask;

    // one-hot position of a tracked key in KEY_STATE; zero for untracked codes
    function automatic logic [4:0] track(input logic [7:0] c, input logic x);
        return {~x && c == 8'h29, x && c == 8'h74, x && c == 8'h6B, x && c == 8'h72, x && c == 8'h75};
    endfunction

    assign is_e0 = BYTE_DATA == 8'hE0;
    assign is_f0 = BYTE_DATA == 8'hF0;
    assign is_e1 = BYTE_DATA == 8'hE1;
    assign mask  = track(BYTE_DATA, ev_ext);

    always_comb begin
        nxt    = state;
        ev     = 1'b0;
        ev_ext = 1'b0;
        ev_rel = 1'b0;
        err    = 1'b0;
        if (BYTE_VALID) begin
            if (BYTE_ERR) begin
                err = 1'b1;
                nxt = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        nxt = is_e0 ? EXT : is_f0 ? BRK : is_e1 ? SKIP : IDLE;
                        ev  = ~(is_e0 | is_f0 | is_e1);
                    end
                    EXT: begin
                        nxt    = is_f0 ? EXT_BRK : IDLE;
                        err    = is_e0 | is_e1;
                        ev     = ~(is_e0 | is_e1 | is_f0);
                        ev_ext = 1'b1;
                    end
                    BRK, EXT_BRK: begin
                        nxt    = IDLE;
                        err    = is_e0 | is_f0 | is_e1;
                        ev     = ~(is_e0 | is_f0 | is_e1);
                        ev_ext = state == EXT_BRK;
                        ev_rel = 1'b1;
                    end
                    SKIP:    nxt = skip == 3'd1 ? IDLE : SKIP;
                    default: nxt = IDLE;
                endcase
            end
        end else if (state != IDLE && tcnt == TLAST) begin
            err = 1'b1;
            nxt = IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            skip        <= '0;
            tcnt        <= '0;
            EVT_VALID   <= 1'b0;
            EVT_CODE    <= 8'h00;
            EVT_EXT     <= 1'b0;
            EVT_RELEASE <= 1'b0;
            EVT_REPEAT  <= 1'b0;
            KEY_STATE   <= '0;
            SEQ_ERR     <= 1'b0;
        end else begin
            state     <= nxt;
            skip      <= nxt == SKIP ? (state == SKIP ? skip - 3'(BYTE_VALID) : 3'd7) : 3'd0;
            tcnt      <= (BYTE_VALID || nxt == IDLE) ? '0 : tcnt + 1'b1;
            EVT_VALID <= ev;
            SEQ_ERR   <= err;
            if (ev) begin
                EVT_CODE    <= BYTE_DATA;
                EVT_EXT     <= ev_ext;
                EVT_RELEASE <= ev_rel;
                EVT_REPEAT  <= ~ev_rel && |(mask & KEY_STATE);
                KEY_STATE   <= ev_rel ? KEY_STATE & ~mask : KEY_STATE | mask;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: table-driven byte vectors plus hand sequences for timeout, byte-vs-timeout and reset
module tb_ps2_key_tracker;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BYTE_VALID = 1'b0;
    logic [7:0] BYTE_DATA = 8'h00;
    logic       BYTE_ERR = 1'b0;
    logic       EVT_VALID, EVT_EXT, EVT_RELEASE, EVT_REPEAT, SEQ_ERR;
    logic [7:0] EVT_CODE;
    logic [4:0] KEY_STATE;

    int checks = 0;
    int errors = 0;

    ps2_key_tracker #(.TIMEOUT_CYC(16)) dut (
        .CLK(CLK), .RST(RST), .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA), .BYTE_ERR(BYTE_ERR),
        .EVT_VALID(EVT_VALID), .EVT_CODE(EVT_CODE), .EVT_EXT(EVT_EXT), .EVT_RELEASE(EVT_RELEASE),
        .EVT_REPEAT(EVT_REPEAT), .KEY_STATE(KEY_STATE), .SEQ_ERR(SEQ_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       evt;
        logic       ext;
        logic       rel;
        logic       rep;
        logic       seq;
        logic [4:0] keys;
    } vec_t;

    vec_t vq[$];

    task automatic p(input logic [7:0] d, input logic e, input logic s, input logic [4:0] k);
        vq.push_back('{d, e, 1'b0, 1'b0, 1'b0, 1'b0, s, k});
    endtask

    task automatic ev(input logic [7:0] d, input logic x, input logic r, input logic rp, input logic [4:0] k);
        vq.push_back('{d, 1'b0, 1'b1, x, r, rp, 1'b0, k});
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic e);
        @(negedge CLK);
        BYTE_VALID = 1'b1;
        BYTE_DATA  = d;
        BYTE_ERR   = e;
        @(posedge CLK);
        #1;
        BYTE_VALID = 1'b0;
        BYTE_ERR   = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int first, pulses;
        // up make/break
        p(8'hE0, 0, 0, 5'b00000);
        ev(8'h75, 1, 0, 0, 5'b00001);
        p(8'hE0, 0, 0, 5'b00001);
        p(8'hF0, 0, 0, 5'b00001);
        ev(8'h75, 1, 1, 0, 5'b00000);
        // space make, repeat, break
        ev(8'h29, 0, 0, 0, 5'b10000);
        ev(8'h29, 0, 0, 1, 5'b10000);
        p(8'hF0, 0, 0, 5'b10000);
        ev(8'h29, 0, 1, 0, 5'b00000);
        // pause sequence swallowed
        p(8'hE1, 0, 0, 0); p(8'h14, 0, 0, 0); p(8'h77, 0, 0, 0); p(8'hE1, 0, 0, 0);
        p(8'hF0, 0, 0, 0); p(8'h14, 0, 0, 0); p(8'hF0, 0, 0, 0); p(8'h77, 0, 0, 0);
        ev(8'h1C, 0, 0, 0, 5'b00000);
        // error byte, illegal prefixes
        p(8'hE0, 1, 1, 0);
        ev(8'h75, 0, 0, 0, 5'b00000);
        p(8'hE0, 0, 0, 0); p(8'hE0, 0, 1, 0);
        p(8'hF0, 0, 0, 0); p(8'hF0, 0, 1, 0);
        p(8'hE0, 0, 0, 0); ev(8'h29, 1, 0, 0, 5'b00000);
        // down make, repeat, unheld extended break, release
        p(8'hE0, 0, 0, 0); ev(8'h72, 1, 0, 0, 5'b00010);
        p(8'hE0, 0, 0, 5'b00010); ev(8'h72, 1, 0, 1, 5'b00010);
        p(8'hE0, 0, 0, 5'b00010); p(8'hF0, 0, 0, 5'b00010); ev(8'h74, 1, 1, 0, 5'b00010);
        p(8'hE0, 0, 0, 5'b00010); p(8'hF0, 0, 0, 5'b00010); ev(8'h72, 1, 1, 0, 5'b00000);
        p(8'hE0, 0, 0, 0); p(8'hE1, 0, 1, 0);
        p(8'hF0, 0, 0, 0); p(8'hE1, 0, 1, 0);
        p(8'hE0, 0, 0, 0); p(8'hF0, 0, 0, 0); p(8'hE0, 0, 1, 0);
        p(8'hE0, 0, 0, 0); p(8'hF0, 0, 0, 0); p(8'hF0, 0, 1, 0);
        // error inside pause sequence
        p(8'hE1, 0, 0, 0); p(8'h14, 0, 0, 0); p(8'h77, 1, 1, 0);
        ev(8'h1C, 0, 0, 0, 5'b00000);
        // extended-ness must match
        p(8'hE0, 0, 0, 0); ev(8'h75, 1, 0, 0, 5'b00001);
        ev(8'h29, 0, 0, 0, 5'b10001);
        p(8'hE0, 0, 0, 5'b10001); p(8'hF0, 0, 0, 5'b10001); ev(8'h29, 1, 1, 0, 5'b10001);
        p(8'hF0, 0, 0, 5'b10001); ev(8'h75, 0, 1, 0, 5'b10001);
        p(8'hF0, 0, 0, 5'b10001); p(8'h29, 1, 1, 5'b10001);
        p(8'hF0, 0, 0, 5'b10001); ev(8'h29, 0, 1, 0, 5'b00001);
        p(8'hE0, 0, 0, 5'b00001); p(8'hF0, 0, 0, 5'b00001); ev(8'h75, 1, 1, 0, 5'b00000);

        #12;
        chk("reset_state", 0, {3'b0, EVT_VALID, SEQ_ERR, EVT_CODE, EVT_EXT, EVT_RELEASE, EVT_REPEAT},
            16'h0000);
        chk("reset_keys", 0, {11'b0, KEY_STATE}, 16'h0000);
        @(negedge CLK);
        RST = 1'b0;

        foreach (vq[i]) begin
            send(vq[i].data, vq[i].err);
            chk("flags", i, {9'b0, EVT_VALID, SEQ_ERR, KEY_STATE}, {9'b0, vq[i].evt, vq[i].seq, vq[i].keys});
            if (vq[i].evt)
                chk("event", i, {5'b0, EVT_CODE, EVT_EXT, EVT_RELEASE, EVT_REPEAT},
                    {5'b0, vq[i].data, vq[i].ext, vq[i].rel, vq[i].rep});
        end

        // timeout after E0: SEQ_ERR on the 16th idle cycle, then plain decode
        send(8'hE0, 1'b0);
        first  = -1;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (SEQ_ERR) begin
                pulses++;
                if (first < 0) first = c;
            end
            chk("timeout_no_evt", c, {15'b0, EVT_VALID}, 16'h0000);
        end
        chk("timeout_cycle", 0, 16'(first), 16'd16);
        chk("timeout_pulses", 0, 16'(pulses), 16'd1);
        send(8'h75, 1'b0);
        chk("after_timeout", 0, {EVT_VALID, SEQ_ERR, EVT_EXT, EVT_RELEASE, KEY_STATE, EVT_CODE[6:0]},
            {1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 7'h75});

        // byte arriving on the would-be timeout cycle wins
        send(8'hE0, 1'b0);
        pulses = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (SEQ_ERR) pulses++;
        end
        send(8'h75, 1'b0);
        chk("byte_wins", 0, {8'(pulses), EVT_VALID, SEQ_ERR, EVT_EXT, KEY_STATE},
            {8'd0, 1'b1, 1'b0, 1'b1, 5'b00001});

        // outputs hold between events, then reset mid-sequence
        send(8'hE0, 1'b0);
        chk("hold", 0, {5'b0, EVT_VALID, EVT_CODE, EVT_EXT, EVT_RELEASE}, {5'b0, 1'b0, 8'h75, 1'b1, 1'b0});
        send(8'h6B, 1'b0);
        chk("left_make", 0, {EVT_VALID, EVT_EXT, KEY_STATE, 1'b0, EVT_CODE},
            {1'b1, 1'b1, 5'b00101, 1'b0, 8'h6B});
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("async_reset", 0, {9'b0, EVT_VALID, SEQ_ERR, KEY_STATE}, 16'h0000);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        chk("post_reset_quiet", 0, {14'b0, EVT_VALID, SEQ_ERR}, 16'h0000);
        send(8'h6B, 1'b0);
        chk("post_reset_make", 0, {EVT_VALID, EVT_EXT, EVT_RELEASE, EVT_REPEAT, SEQ_ERR, KEY_STATE[2:0], EVT_CODE},
            {5'b10000, 3'b000, 8'h6B});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
